// File: rtl/led_cube_single_frame_if.sv
// Bus between the frame sequencer and the LED cube refresh engine:
// scan control, frame-byte lookup and the cube drive lines.
interface led_cube_single_frame_if;
    logic       start;
    logic       stop;
    logic       done;
    logic [5:0] addr;
    logic [7:0] data_to_latch;
    logic [7:0] Layers;
    logic [7:0] Latches;
    logic [7:0] Data;

    modport master (
        output start,
        output stop,
        output data_to_latch,
        input  done,
        input  addr,
        input  Layers,
        input  Latches,
        input  Data
    );

    modport slave (
        input  start,
        input  stop,
        input  data_to_latch,
        output done,
        output addr,
        output Layers,
        output Latches,
        output Data
    );
endinterface

// File: rtl/led_cube_single_frame.sv
// Refresh engine for an 8x8x8 LED cube: loads eight row latches per layer,
// then lights that layer for ON_CYCLES cycles, sweeping all eight layers.
module led_cube_single_frame #(
    parameter int unsigned ON_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_cube_single_frame_if.slave bus
);

    localparam int unsigned CNT_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
    localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(ON_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_ON     = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [2:0]       layer_r, layer_s;
    logic [2:0]       row_r, row_s;
    logic [CNT_W-1:0] on_cnt_r, on_cnt_s;
    logic [7:0]       data_r, data_s;
    logic             on_last_s;

    assign on_last_s = (on_cnt_r == ON_LAST);

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            layer_r  <= 3'd0;
            row_r    <= 3'd0;
            on_cnt_r <= '0;
            data_r   <= 8'd0;
        end else begin
            state_r  <= state_s;
            layer_r  <= layer_s;
            row_r    <= row_s;
            on_cnt_r <= on_cnt_s;
            data_r   <= data_s;
        end
    end

    // Next-state logic; stop outranks start, and start outranks the scan itself.
    always_comb begin
        state_s  = state_r;
        layer_s  = layer_r;
        row_s    = row_r;
        on_cnt_s = on_cnt_r;
        data_s   = data_r;
        if (bus.stop) begin
            state_s  = S_IDLE;
            layer_s  = 3'd0;
            row_s    = 3'd0;
            on_cnt_s = '0;
            data_s   = 8'd0;
        end else if (bus.start) begin
            state_s  = S_SETUP;
            layer_s  = 3'd0;
            row_s    = 3'd0;
            on_cnt_s = '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_IDLE;
                end
                S_SETUP: begin
                    data_s  = bus.data_to_latch;
                    state_s = S_STROBE;
                end
                S_STROBE: begin
                    state_s = S_HOLD;
                end
                S_HOLD: begin
                    if (row_r == 3'd7) begin
                        state_s  = S_ON;
                        on_cnt_s = '0;
                    end else begin
                        row_s   = row_r + 3'd1;
                        state_s = S_SETUP;
                    end
                end
                S_ON: begin
                    // layer 7 + 1 wraps to 0, starting the next sweep
                    if (on_last_s) begin
                        state_s  = S_SETUP;
                        row_s    = 3'd0;
                        layer_s  = layer_r + 3'd1;
                        on_cnt_s = '0;
                    end else begin
                        on_cnt_s = on_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s  = S_IDLE;
                    layer_s  = 3'd0;
                    row_s    = 3'd0;
                    on_cnt_s = '0;
                    data_s   = 8'd0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so no input reaches them combinationally.
    assign bus.addr    = {layer_r, row_r};
    assign bus.Data    = data_r;
    assign bus.Layers  = (state_r == S_ON)     ? (8'd1 << layer_r) : 8'd0;
    assign bus.Latches = (state_r == S_STROBE) ? (8'd1 << row_r)   : 8'd0;
    assign bus.done    = (state_r == S_ON) && on_last_s && (layer_r == 3'd7);

endmodule

// File: tb/tb_led_cube_single_frame.sv
// Randomized bench for led_cube_single_frame: every cycle is compared against
// a timeline model that derives the expected drive from cycles since start.
module tb_led_cube_single_frame;

    localparam int ON_C = 4;
    localparam int PER  = 24 + ON_C;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_cube_single_frame_if ifc ();

    led_cube_single_frame #(.ON_CYCLES(ON_C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    logic [7:0] mem [64];
    always_comb ifc.data_to_latch = mem[ifc.addr];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit chk_en   = 1'b0;
    bit run_m    = 1'b0;
    int t_m      = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference timeline: t_m counts cycles since the accepted start.
    always @(posedge clk) begin
        if (!rst_n || ifc.stop) begin
            run_m <= 1'b0;
            t_m   <= 0;
        end else if (ifc.start) begin
            run_m <= 1'b1;
            t_m   <= 1;
        end else if (run_m) begin
            t_m <= t_m + 1;
        end
    end

    task automatic compare_outputs();
        int p, sub;
        logic [2:0] el, er;
        logic [7:0] e_lay, e_lat, e_data;
        logic e_done;
        bit data_known;
        el = 3'd0; er = 3'd0; e_lay = 8'd0; e_lat = 8'd0; e_data = 8'd0;
        e_done = 1'b0; data_known = 1'b1;
        if (run_m) begin
            p  = (t_m - 1) % PER;
            el = 3'((t_m - 1) / PER % 8);
            if (p < 24) begin
                er  = 3'(p / 3);
                sub = p % 3;
                if (sub == 1) e_lat = 8'd1 << er;
                data_known = (sub != 0);
                e_data = mem[{el, er}];
            end else begin
                er     = 3'd7;
                e_lay  = 8'd1 << el;
                e_data = mem[{el, 3'd7}];
                e_done = (p == PER - 1) && (el == 3'd7);
            end
        end
        check_val("addr",    32'(ifc.addr),    32'({el, er}));
        check_val("Layers",  32'(ifc.Layers),  32'(e_lay));
        check_val("Latches", 32'(ifc.Latches), 32'(e_lat));
        check_val("done",    32'(ifc.done),    32'(e_done));
        if (data_known) check_val("Data", 32'(ifc.Data), 32'(e_data));
        if (ifc.done === 1'b1) done_cnt++;
    endtask

    always @(negedge clk) if (chk_en) compare_outputs();

    task automatic step(input logic s, input logic p);
        ifc.start = s;
        ifc.stop  = p;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = 8'(a) ^ 8'h5A;
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(2);
        rst_n = 1'b1;

        // idle with no start: everything stays dark
        idle(20);

        // two full sweeps; done must appear exactly twice
        done_cnt = 0;
        step(1'b1, 1'b0);
        idle(2 * 8 * PER + 10);
        check_val("done_count", 32'(done_cnt), 32'd2);

        // stop in the first ON cycle of layer 3, then resume
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        idle(3 * PER + 24);
        step(1'b0, 1'b1);
        idle(5);
        step(1'b1, 1'b0);
        idle(40);

        // restart during the row-2 strobe of layer 5; no done may follow
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        idle(5 * PER + 7);
        done_cnt = 0;
        step(1'b1, 1'b0);
        idle(30);
        check_val("done_after_restart", 32'(done_cnt), 32'd0);

        // simultaneous start and stop: stop wins
        step(1'b1, 1'b1);
        idle(5);

        // reset in the middle of layer 2 ON
        step(1'b1, 1'b0);
        idle(2 * PER + 26);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(5);

        // random frame contents and random start/stop traffic
        for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 499);
            step(r == 0, r == 1 || r == 2);
            if (r == 1) idle(3);
            if (r == 2) step(1'b1, 1'b0);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
